// File: rtl/frac_div_pkg.sv
// frac_div_pkg
// Shared definitions for the fractional clock-enable scheduler:
//   state_t       - scheduler FSM states (IDLE, RUN, PEND)
//   W_DEF         - default width of the ratio fields
//   INIT_IN_DEF   - default DIV_IN loaded at reset
//   INIT_OUT_DEF  - default DIV_OUT loaded at reset
package frac_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2   // running with a new ratio waiting in the shadow
   } state_t;

   localparam int unsigned W_DEF        = 8;
   localparam int unsigned INIT_IN_DEF  = 3;
   localparam int unsigned INIT_OUT_DEF = 2;

endpackage

// File: rtl/frac_div_accum.sv
// frac_div_accum
// Phase accumulator and period counter of the fractional divider.
// Each evaluating cycle adds div_out to acc; when the sum reaches div_in an
// enable pulse is registered and div_in is subtracted. cnt counts the
// div_in cycles of one period and wraps to 0 on the last one.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   eval          - 1 = evaluate this cycle; 0 = hold acc/cnt cleared
//   div_in        - input cycles per period
//   div_out       - enable pulses per period
//   wrap          - combinational: this cycle is the last of the period
//   en_out        - registered enable pulse
//   period_done   - registered end-of-period pulse
module frac_div_accum #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         eval,
   input  logic [W-1:0] div_in,
   input  logic [W-1:0] div_out,
   output logic         wrap,
   output logic         en_out,
   output logic         period_done
);

   logic [W-1:0] acc;
   logic [W-1:0] cnt;
   logic [W:0]   sum;
   logic [W:0]   diff;
   logic         hit;
   logic [W-1:0] acc_nxt;

   always_comb begin
      sum     = {1'b0, acc} + {1'b0, div_out};
      diff    = sum - {1'b0, div_in};
      hit     = (sum >= {1'b0, div_in});
      acc_nxt = hit ? diff[W-1:0] : sum[W-1:0];
      wrap    = eval && (cnt == (div_in - W'(1)));
   end

   always_ff @(posedge clk) begin
      if (rst || !eval) begin
         acc         <= '0;
         cnt         <= '0;
         en_out      <= 1'b0;
         period_done <= 1'b0;
      end else begin
         en_out      <= hit;
         period_done <= wrap;
         // acc is forced to 0 at the wrap so a ratio swapped in from the
         // shadow always starts from a clean phase.
         if (wrap) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= acc_nxt;
            cnt <= cnt + W'(1);
         end
      end
   end

endmodule

// File: rtl/frac_div_sched.sv
// frac_div_sched
// Fractional clock-enable scheduler: emits DIV_OUT one-cycle enable pulses
// spread evenly over every DIV_IN input cycles. A new ratio arrives over a
// valid/ready handshake; while running it is parked in a shadow register
// and applied at the next period boundary.
// Optional feature: define FRAC_DIV_CLKOUT_EN to add CLK_out, a divided
// clock that toggles on the edge after each EN_out pulse.
// Ports:
//   CLK_in       - the one clock (rising edge)
//   RST          - synchronous active-high reset
//   run          - level: 1 = generate enables, 0 = stop
//   cfg_valid    - new ratio offered
//   cfg_ready    - ratio can be accepted this cycle
//   cfg_in       - new DIV_IN
//   cfg_out      - new DIV_OUT
//   EN_out       - registered clock-enable pulse
//   period_done  - registered pulse on the last cycle of each period
//   cfg_err      - sticky flag for a rejected ratio
//   CLK_out      - divided clock (FRAC_DIV_CLKOUT_EN only)
module frac_div_sched
   import frac_div_pkg::*;
#(
   parameter int unsigned W        = W_DEF,
   parameter int unsigned INIT_IN  = INIT_IN_DEF,
   parameter int unsigned INIT_OUT = INIT_OUT_DEF
) (
   input  logic         CLK_in,
   input  logic         RST,
   input  logic         run,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   input  logic [W-1:0] cfg_in,
   input  logic [W-1:0] cfg_out,
   output logic         EN_out,
   output logic         period_done,
   output logic         cfg_err
`ifdef FRAC_DIV_CLKOUT_EN
   ,
   output logic         CLK_out
`endif
);

   state_t       state;
   logic [W-1:0] div_in;
   logic [W-1:0] div_out;
   logic [W-1:0] sh_in;
   logic [W-1:0] sh_out;
   logic         shadow_vld;
   logic         eval;
   logic         wrap;
   logic         xfer;
   logic         ratio_ok;

   always_comb begin
      eval     = run && (state != IDLE);
      xfer     = cfg_valid && cfg_ready;
      ratio_ok = (cfg_in != '0) && (cfg_out != '0) && (cfg_out <= cfg_in);
   end

   always_ff @(posedge CLK_in) begin
      if (RST) begin
         state      <= IDLE;
         div_in     <= W'(INIT_IN);
         div_out    <= W'(INIT_OUT);
         sh_in      <= '0;
         sh_out     <= '0;
         shadow_vld <= 1'b0;
         cfg_err    <= 1'b0;
         cfg_ready  <= 1'b1;
      end else begin
         if (xfer)
            cfg_err <= !ratio_ok;

         unique case (state)
            IDLE: begin
               // A ratio offered directly in IDLE supersedes any shadow.
               if (xfer && ratio_ok) begin
                  div_in     <= cfg_in;
                  div_out    <= cfg_out;
                  shadow_vld <= 1'b0;
               end else if (run && shadow_vld) begin
                  div_in     <= sh_in;
                  div_out    <= sh_out;
                  shadow_vld <= 1'b0;
               end
               if (run)
                  state <= RUN;
               cfg_ready <= 1'b1;
            end

            RUN: begin
               if (xfer && ratio_ok) begin
                  sh_in      <= cfg_in;
                  sh_out     <= cfg_out;
                  shadow_vld <= 1'b1;
               end
               // Stopping with a ratio in flight keeps it in the shadow; it
               // is applied on the next IDLE->RUN edge.
               if (!run) begin
                  state     <= IDLE;
                  cfg_ready <= 1'b1;
               end else if (xfer && ratio_ok) begin
                  state     <= PEND;
                  cfg_ready <= 1'b0;
               end
            end

            PEND: begin
               if (!run) begin
                  state     <= IDLE;
                  cfg_ready <= 1'b1;
               end else if (wrap) begin
                  div_in     <= sh_in;
                  div_out    <= sh_out;
                  shadow_vld <= 1'b0;
                  state      <= RUN;
                  cfg_ready  <= 1'b1;
               end
            end

            default: begin
               state     <= IDLE;
               cfg_ready <= 1'b1;
            end
         endcase
      end
   end

   frac_div_accum #(
      .W (W)
   ) u_accum (
      .clk         (CLK_in),
      .rst         (RST),
      .eval        (eval),
      .div_in      (div_in),
      .div_out     (div_out),
      .wrap        (wrap),
      .en_out      (EN_out),
      .period_done (period_done)
   );

`ifdef FRAC_DIV_CLKOUT_EN
   always_ff @(posedge CLK_in) begin
      if (RST)
         CLK_out <= 1'b0;
      else if (EN_out)
         CLK_out <= ~CLK_out;
   end
`endif

endmodule

// File: tb/tb_frac_div_sched.sv
// tb_frac_div_sched
// Directed bench for frac_div_sched with hand-computed enable patterns.
// Inputs change 1 time unit after each rising edge; outputs are sampled at
// the same point, so each sample reflects the edge just taken.
module tb_frac_div_sched;

   logic       CLK_in = 1'b0;
   logic       RST;
   logic       run;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [7:0] cfg_in;
   logic [7:0] cfg_out;
   logic       EN_out;
   logic       period_done;
   logic       cfg_err;
`ifdef FRAC_DIV_CLKOUT_EN
   logic       CLK_out;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK_in = ~CLK_in;

   frac_div_sched #(
      .W        (8),
      .INIT_IN  (3),
      .INIT_OUT (2)
   ) dut (
      .CLK_in      (CLK_in),
      .RST         (RST),
      .run         (run),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_in      (cfg_in),
      .cfg_out     (cfg_out),
      .EN_out      (EN_out),
      .period_done (period_done),
      .cfg_err     (cfg_err)
`ifdef FRAC_DIV_CLKOUT_EN
      ,
      .CLK_out     (CLK_out)
`endif
   );

   task automatic tick();
      @(posedge CLK_in);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; run = 1'b1; cfg_valid = 1'b1; cfg_in = 8'd5; cfg_out = 8'd4;
      tick(); tick();
      n_cmp++; if (EN_out !== 1'b0) begin n_bad++; $display("FAIL reset_en got=%b exp=0", EN_out); end
      n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL reset_pd got=%b exp=0", period_done); end
      n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
      n_cmp++; if (dut.shadow_vld !== 1'b0) begin n_bad++; $display("FAIL reset_shadow got=%b exp=0", dut.shadow_vld); end
      RST = 1'b0; cfg_valid = 1'b0;
   endtask

   // 3/2 from reset: EN 0,1,1 with period_done on the third
   task automatic test_default_ratio();
      logic [2:0] pat = 3'b110;
      run = 1'b1;
      tick();
      n_cmp++; if (EN_out !== 1'b0) begin n_bad++; $display("FAIL dflt_entry_en got=%b exp=0", EN_out); end
      for (int i = 0; i < 9; i++) begin
         tick();
         n_cmp++; if (EN_out !== pat[i % 3]) begin n_bad++; $display("FAIL dflt_en[%0d] got=%b exp=%b", i, EN_out, pat[i % 3]); end
         n_cmp++; if (period_done !== ((i % 3) == 2)) begin n_bad++; $display("FAIL dflt_pd[%0d] got=%b exp=%b", i, period_done, (i % 3) == 2); end
         if ((i % 3) == 2) begin
            n_cmp++; if (dut.u_accum.acc !== 8'd0) begin n_bad++; $display("FAIL dflt_acc[%0d] got=%0d exp=0", i, dut.u_accum.acc); end
         end
      end
   endtask

   // 5/4 offered mid-period: old period completes, then 0,1,1,1,1
   task automatic test_shadow_swap();
      logic [4:0] pat = 5'b11110;
      tick();
      n_cmp++; if (EN_out !== 1'b0) begin n_bad++; $display("FAIL swap_pre_en got=%b exp=0", EN_out); end
      cfg_valid = 1'b1; cfg_in = 8'd5; cfg_out = 8'd4;
      tick();
      n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL swap_ready_drop got=%b exp=0", cfg_ready); end
      n_cmp++; if (EN_out !== 1'b1) begin n_bad++; $display("FAIL swap_mid_en got=%b exp=1", EN_out); end
      cfg_valid = 1'b0;
      tick();
      n_cmp++; if (EN_out !== 1'b1) begin n_bad++; $display("FAIL swap_last_en got=%b exp=1", EN_out); end
      n_cmp++; if (period_done !== 1'b1) begin n_bad++; $display("FAIL swap_last_pd got=%b exp=1", period_done); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL swap_ready_back got=%b exp=1", cfg_ready); end
      for (int i = 0; i < 10; i++) begin
         tick();
         n_cmp++; if (EN_out !== pat[i % 5]) begin n_bad++; $display("FAIL swap_en[%0d] got=%b exp=%b", i, EN_out, pat[i % 5]); end
         n_cmp++; if (period_done !== ((i % 5) == 4)) begin n_bad++; $display("FAIL swap_pd[%0d] got=%b exp=%b", i, period_done, (i % 5) == 4); end
      end
   endtask

   // run=0 together with a 4/1 offer: held in shadow, applied on restart
   task automatic test_stop_accept();
      logic [3:0] pat = 4'b1000;
      run = 1'b0; cfg_valid = 1'b1; cfg_in = 8'd4; cfg_out = 8'd1;
      tick();
      n_cmp++; if (EN_out !== 1'b0) begin n_bad++; $display("FAIL stop_en got=%b exp=0", EN_out); end
      n_cmp++; if (dut.shadow_vld !== 1'b1) begin n_bad++; $display("FAIL stop_shadow got=%b exp=1", dut.shadow_vld); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL stop_ready got=%b exp=1", cfg_ready); end
      cfg_valid = 1'b0;
      tick();
      n_cmp++; if (EN_out !== 1'b0) begin n_bad++; $display("FAIL stop_idle_en got=%b exp=0", EN_out); end
      run = 1'b1;
      tick();
      n_cmp++; if (dut.shadow_vld !== 1'b0) begin n_bad++; $display("FAIL stop_shadow_load got=%b exp=0", dut.shadow_vld); end
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++; if (EN_out !== pat[i % 4]) begin n_bad++; $display("FAIL stop_en[%0d] got=%b exp=%b", i, EN_out, pat[i % 4]); end
         n_cmp++; if (period_done !== ((i % 4) == 3)) begin n_bad++; $display("FAIL stop_pd[%0d] got=%b exp=%b", i, period_done, (i % 4) == 3); end
      end
   endtask

   // 35/12 loaded in IDLE, 350 cycles -> 120 enables, 10 periods
   task automatic test_ratio_35_12();
      int en_cnt = 0;
      int pd_cnt = 0;
      run = 1'b0;
      tick();
      cfg_valid = 1'b1; cfg_in = 8'd35; cfg_out = 8'd12;
      tick();
      cfg_valid = 1'b0; run = 1'b1;
      tick();
      for (int i = 0; i < 350; i++) begin
         tick();
         if (EN_out === 1'b1) en_cnt++;
         if (period_done === 1'b1) begin
            pd_cnt++;
            n_cmp++; if (dut.u_accum.acc !== 8'd0) begin n_bad++; $display("FAIL r35_acc[%0d] got=%0d exp=0", i, dut.u_accum.acc); end
         end
      end
      n_cmp++; if (en_cnt !== 120) begin n_bad++; $display("FAIL r35_en_count got=%0d exp=120", en_cnt); end
      n_cmp++; if (pd_cnt !== 10) begin n_bad++; $display("FAIL r35_pd_count got=%0d exp=10", pd_cnt); end
   endtask

   // rejects leave 35/12 running; 7/7 clears the error and gives EN every cycle
   task automatic test_cfg_err();
      int en_cnt = 0;
      int pd_cnt = 0;
      int pd_at  = -1;
      cfg_valid = 1'b1; cfg_in = 8'd4; cfg_out = 8'd5;
      tick();
      if (EN_out === 1'b1) en_cnt++;
      n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_set got=%b exp=1", cfg_err); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL err_ready got=%b exp=1", cfg_ready); end
      cfg_in = 8'd0; cfg_out = 8'd0;
      tick();
      if (EN_out === 1'b1) en_cnt++;
      n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky got=%b exp=1", cfg_err); end
      cfg_valid = 1'b0;
      for (int i = 2; i < 35; i++) begin
         tick();
         if (EN_out === 1'b1) en_cnt++;
         if (period_done === 1'b1) begin pd_cnt++; pd_at = i; end
      end
      n_cmp++; if (en_cnt !== 12) begin n_bad++; $display("FAIL err_keep_en got=%0d exp=12", en_cnt); end
      n_cmp++; if (pd_cnt !== 1 || pd_at !== 34) begin n_bad++; $display("FAIL err_keep_pd got=%0d@%0d exp=1@34", pd_cnt, pd_at); end
      cfg_valid = 1'b1; cfg_in = 8'd7; cfg_out = 8'd7;
      tick();
      n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_clear got=%b exp=0", cfg_err); end
      n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL err_pend got=%b exp=0", cfg_ready); end
      cfg_valid = 1'b0;
      for (int i = 1; i < 35; i++) tick();
      n_cmp++; if (period_done !== 1'b1) begin n_bad++; $display("FAIL err_swap_pd got=%b exp=1", period_done); end
      for (int i = 0; i < 14; i++) begin
         tick();
         n_cmp++; if (EN_out !== 1'b1) begin n_bad++; $display("FAIL full_en[%0d] got=%b exp=1", i, EN_out); end
         n_cmp++; if (period_done !== ((i % 7) == 6)) begin n_bad++; $display("FAIL full_pd[%0d] got=%b exp=%b", i, period_done, (i % 7) == 6); end
      end
   endtask

   // RST while PEND holds 9/4: back to IDLE, shadow dropped, 3/2 on restart
   task automatic test_reset_mid();
      logic [2:0] pat = 3'b110;
      cfg_valid = 1'b1; cfg_in = 8'd9; cfg_out = 8'd4;
      tick();
      n_cmp++; if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_pend got=%b exp=0", cfg_ready); end
      cfg_valid = 1'b0;
      tick();
      RST = 1'b1;
      tick();
      n_cmp++; if (EN_out !== 1'b0) begin n_bad++; $display("FAIL rmid_en got=%b exp=0", EN_out); end
      n_cmp++; if (period_done !== 1'b0) begin n_bad++; $display("FAIL rmid_pd got=%b exp=0", period_done); end
      n_cmp++; if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got=%b exp=1", cfg_ready); end
      n_cmp++; if (dut.shadow_vld !== 1'b0) begin n_bad++; $display("FAIL rmid_shadow got=%b exp=0", dut.shadow_vld); end
      RST = 1'b0;
      tick();
      n_cmp++; if (EN_out !== 1'b0) begin n_bad++; $display("FAIL rmid_entry_en got=%b exp=0", EN_out); end
      for (int i = 0; i < 6; i++) begin
         tick();
         n_cmp++; if (EN_out !== pat[i % 3]) begin n_bad++; $display("FAIL rmid_en[%0d] got=%b exp=%b", i, EN_out, pat[i % 3]); end
         n_cmp++; if (period_done !== ((i % 3) == 2)) begin n_bad++; $display("FAIL rmid_pd[%0d] got=%b exp=%b", i, period_done, (i % 3) == 2); end
      end
   endtask

`ifdef FRAC_DIV_CLKOUT_EN
   // 3/2 from reset: CLK_out follows EN_out by one edge -> 0,0,0,1,0,0,1,0
   task automatic test_clkout();
      logic [7:0] exp_clk = 8'b0100_1000;
      RST = 1'b1; run = 1'b0; cfg_valid = 1'b0;
      tick();
      n_cmp++; if (CLK_out !== 1'b0) begin n_bad++; $display("FAIL clk_reset got=%b exp=0", CLK_out); end
      RST = 1'b0; run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_cmp++; if (CLK_out !== exp_clk[i]) begin n_bad++; $display("FAIL clk_out[%0d] got=%b exp=%b", i, CLK_out, exp_clk[i]); end
      end
   endtask
`endif

   initial begin
      RST = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_in = '0; cfg_out = '0;
      test_reset();
      test_default_ratio();
      test_shadow_swap();
      test_stop_accept();
      test_ratio_35_12();
      test_cfg_err();
      test_reset_mid();
`ifdef FRAC_DIV_CLKOUT_EN
      test_clkout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
